// File: rtl/bexkat1_ifetch.sv
// bexkat1 instruction fetch: Wishbone-classic read master that builds 1- or 2-word
// instructions and hands one instruction or a zero bubble per cycle to decode.
module bexkat1_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FAULT_PC = 32'h0000_0008
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {S_W0, S_W1, S_HOLD, S_REDIR} state_t;

  state_t      state, state_nx;
  logic        run;
  logic [31:0] fpc, fpc_nx;
  logic [31:0] w0, w0_nx;
  logic [31:0] wpc, wpc_nx;
  logic [63:0] hir, hir_nx;
  logic [31:0] hpc, hpc_nx;
  logic        fault_nx;
  logic        issue;
  logic [63:0] iss_ir;
  logic [31:0] iss_pc;
  logic        cmp;
  logic [63:0] cmp_ir;
  logic [31:0] cmp_pc;
  logic        cyc, ack, err;

  // run keeps the bus quiet during reset and for the first cycle after release
  assign cyc       = run && ((state == S_W0) || (state == S_W1));
  assign ack       = bus_ack_i && cyc;
  assign err       = bus_err_i && cyc;
  assign bus_cyc_o = cyc;
  assign bus_stb_o = cyc;
  assign bus_adr_o = fpc;

  always_comb begin
    state_nx = state;
    fpc_nx   = fpc;
    w0_nx    = w0;
    wpc_nx   = wpc;
    hir_nx   = hir;
    hpc_nx   = hpc;
    fault_nx = 1'b0;
    issue    = 1'b0;
    iss_ir   = 64'h0;
    iss_pc   = 32'h0;
    cmp      = 1'b0;
    cmp_ir   = 64'h0;
    cmp_pc   = 32'h0;
    if (pc_set_i) begin
      fpc_nx   = pc_target_i;
      state_nx = S_REDIR;
    end else if (err) begin
      fpc_nx   = FAULT_PC;
      state_nx = S_REDIR;
      fault_nx = 1'b1;
    end else begin
      case (state)
        S_W0: begin
          if (ack) begin
            fpc_nx = fpc + 32'd4;
            if (bus_dat_i[0]) begin
              w0_nx    = bus_dat_i;
              wpc_nx   = fpc;
              state_nx = S_W1;
            end else begin
              cmp    = 1'b1;
              cmp_ir = {32'h0, bus_dat_i};
              cmp_pc = fpc;
            end
          end
        end
        S_W1: begin
          if (ack) begin
            fpc_nx = fpc + 32'd4;
            cmp    = 1'b1;
            cmp_ir = {bus_dat_i, w0};
            cmp_pc = wpc;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            issue    = 1'b1;
            iss_ir   = hir;
            iss_pc   = hpc;
            state_nx = S_W0;
          end
        end
        default: state_nx = S_W0;
      endcase
      // a completed instruction either issues now or parks in S_HOLD
      if (cmp) begin
        if (stall_i) begin
          hir_nx   = cmp_ir;
          hpc_nx   = cmp_pc;
          state_nx = S_HOLD;
        end else begin
          issue    = 1'b1;
          iss_ir   = cmp_ir;
          iss_pc   = cmp_pc;
          state_nx = S_W0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_W0;
      run     <= 1'b0;
      fpc     <= RESET_PC;
      w0      <= 32'h0;
      wpc     <= 32'h0;
      hir     <= 64'h0;
      hpc     <= 32'h0;
      ir_o    <= 64'h0;
      pc_o    <= 32'h0;
      fault_o <= 1'b0;
    end else begin
      state   <= state_nx;
      run     <= 1'b1;
      fpc     <= fpc_nx;
      w0      <= w0_nx;
      wpc     <= wpc_nx;
      hir     <= hir_nx;
      hpc     <= hpc_nx;
      fault_o <= fault_nx;
      if (!stall_i) begin
        ir_o <= issue ? iss_ir : 64'h0;
        pc_o <= issue ? iss_pc : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_bexkat1_ifetch.sv
// Directed bench for bexkat1_ifetch with a small wait-state-programmable memory slave.
module tb_bexkat1_ifetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        pc_set_i = 1'b0;
  logic [31:0] pc_target_i = 32'h0;
  logic        bus_cyc_o, bus_stb_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i, bus_err_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic        fault_o;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:127];
  logic [1:0]  nwait = 2'd0;
  logic [1:0]  wcnt  = 2'd0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = 32'h0;
  logic        hit, err_hit;

  bexkat1_ifetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .pc_set_i(pc_set_i),
    .pc_target_i(pc_target_i), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_adr_o(bus_adr_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .ir_o(ir_o), .pc_o(pc_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  assign hit       = bus_cyc_o && bus_stb_o;
  assign err_hit   = err_en && hit && (bus_adr_o == err_adr);
  assign bus_err_i = err_hit;
  assign bus_ack_i = hit && !err_hit && (wcnt == nwait);
  assign bus_dat_i = mem[bus_adr_o[8:2]];

  always @(posedge clk_i) begin
    if (hit && !bus_ack_i) wcnt <= wcnt + 2'd1;
    else wcnt <= 2'd0;
  end

  task automatic do_reset;
    @(negedge clk_i);
    rst_i = 1'b0;
    stall_i = 1'b0; pc_set_i = 1'b0; pc_target_i = 32'h0;
    err_en = 1'b0; nwait = 2'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (bus_cyc_o !== 1'b0) $display("FAIL rst_cyc got %b want 0", bus_cyc_o); else passed++;
    total++; if (bus_stb_o !== 1'b0) $display("FAIL rst_stb got %b want 0", bus_stb_o); else passed++;
    total++; if (bus_adr_o !== 32'h0) $display("FAIL rst_adr got %h want 0", bus_adr_o); else passed++;
    total++; if (ir_o !== 64'h0) $display("FAIL rst_ir got %h want 0", ir_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL rst_pc got %h want 0", pc_o); else passed++;
    total++; if (fault_o !== 1'b0) $display("FAIL rst_fault got %b want 0", fault_o); else passed++;
    rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (bus_cyc_o !== 1'b1) $display("FAIL rst_first_cyc got %b want 1", bus_cyc_o); else passed++;
    total++; if (bus_adr_o !== 32'h0) $display("FAIL rst_first_adr got %h want 0", bus_adr_o); else passed++;
  endtask

  task automatic test_short;
    do_reset();
    mem[0] = 32'h1000_0000; mem[1] = 32'h2000_0000; mem[2] = 32'h0000_0004;
    rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (bus_adr_o !== 32'h0) $display("FAIL short_adr0 got %h want 0", bus_adr_o); else passed++;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h1000_0000) $display("FAIL short_ir0 got %h want 10000000", ir_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL short_pc0 got %h want 0", pc_o); else passed++;
    total++; if (bus_adr_o !== 32'h4) $display("FAIL short_adr1 got %h want 4", bus_adr_o); else passed++;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h2000_0000) $display("FAIL short_ir1 got %h want 20000000", ir_o); else passed++;
    total++; if (pc_o !== 32'h4) $display("FAIL short_pc1 got %h want 4", pc_o); else passed++;
    total++; if (bus_adr_o !== 32'h8) $display("FAIL short_adr2 got %h want 8", bus_adr_o); else passed++;
  endtask

  task automatic test_long_wait;
    do_reset();
    mem[0] = 32'h3000_0001; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h0000_0010;
    nwait = 2'd1;
    rst_i = 1'b1;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      total++; if (ir_o !== 64'h0) $display("FAIL long_bubble%0d got %h want 0", c, ir_o); else passed++;
      if (c == 1) begin
        total++; if (bus_adr_o !== 32'h4) $display("FAIL long_adr_w1 got %h want 4", bus_adr_o); else passed++;
      end
    end
    @(negedge clk_i);
    total++; if (ir_o !== 64'hDEAD_BEEF_3000_0001) $display("FAIL long_ir got %h want deadbeef30000001", ir_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL long_pc got %h want 0", pc_o); else passed++;
    total++; if (bus_adr_o !== 32'h8) $display("FAIL long_next_adr got %h want 8", bus_adr_o); else passed++;
  endtask

  task automatic test_stall;
    do_reset();
    mem[0] = 32'h1111_0000; mem[1] = 32'h2222_0000; mem[2] = 32'h3333_0000;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    total++; if (ir_o !== 64'h1111_0000) $display("FAIL stall_pre_ir got %h want 11110000", ir_o); else passed++;
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      total++; if (ir_o !== 64'h1111_0000) $display("FAIL stall_hold_ir%0d got %h want 11110000", c, ir_o); else passed++;
      total++; if (pc_o !== 32'h0) $display("FAIL stall_hold_pc%0d got %h want 0", c, pc_o); else passed++;
      total++; if (bus_cyc_o !== 1'b0) $display("FAIL stall_hold_cyc%0d got %b want 0", c, bus_cyc_o); else passed++;
    end
    stall_i = 1'b0;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h2222_0000) $display("FAIL stall_rel_ir got %h want 22220000", ir_o); else passed++;
    total++; if (pc_o !== 32'h4) $display("FAIL stall_rel_pc got %h want 4", pc_o); else passed++;
    total++; if (bus_adr_o !== 32'h8) $display("FAIL stall_rel_adr got %h want 8", bus_adr_o); else passed++;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h3333_0000) $display("FAIL stall_next_ir got %h want 33330000", ir_o); else passed++;
    total++; if (pc_o !== 32'h8) $display("FAIL stall_next_pc got %h want 8", pc_o); else passed++;
  endtask

  task automatic test_redirect;
    do_reset();
    mem[0] = 32'h3000_0001; mem[1] = 32'hDEAD_BEEF; mem[64] = 32'h0000_0100;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    total++; if (bus_adr_o !== 32'h4) $display("FAIL redir_w1_adr got %h want 4", bus_adr_o); else passed++;
    pc_set_i = 1'b1; pc_target_i = 32'h100;
    @(negedge clk_i);
    pc_set_i = 1'b0;
    total++; if (ir_o !== 64'h0) $display("FAIL redir_bub0 got %h want 0", ir_o); else passed++;
    total++; if (bus_cyc_o !== 1'b0) $display("FAIL redir_idle_cyc got %b want 0", bus_cyc_o); else passed++;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h0) $display("FAIL redir_bub1 got %h want 0", ir_o); else passed++;
    total++; if (bus_adr_o !== 32'h100) $display("FAIL redir_adr got %h want 100", bus_adr_o); else passed++;
    @(negedge clk_i);
    total++; if (ir_o !== 64'h100) $display("FAIL redir_ir got %h want 100", ir_o); else passed++;
    total++; if (pc_o !== 32'h100) $display("FAIL redir_pc got %h want 100", pc_o); else passed++;
  endtask

  task automatic test_bus_err(input logic with_set);
    do_reset();
    mem[2] = 32'h0000_0008; mem[64] = 32'h0000_0100;
    err_en = 1'b1; err_adr = 32'h40;
    pc_set_i = 1'b1; pc_target_i = 32'h40;
    rst_i = 1'b1;
    @(negedge clk_i);
    pc_set_i = 1'b0;
    @(negedge clk_i);
    total++; if (bus_adr_o !== 32'h40) $display("FAIL err%0d_adr got %h want 40", with_set, bus_adr_o); else passed++;
    if (with_set) begin pc_set_i = 1'b1; pc_target_i = 32'h100; end
    @(negedge clk_i);
    pc_set_i = 1'b0;
    total++; if (fault_o !== !with_set) $display("FAIL err%0d_fault got %b want %b", with_set, fault_o, !with_set); else passed++;
    total++; if (ir_o !== 64'h0) $display("FAIL err%0d_noissue got %h want 0", with_set, ir_o); else passed++;
    total++; if (bus_adr_o !== (with_set ? 32'h100 : 32'h8)) $display("FAIL err%0d_redir got %h want %h", with_set, bus_adr_o, with_set ? 32'h100 : 32'h8); else passed++;
    @(negedge clk_i);
    total++; if (fault_o !== 1'b0) $display("FAIL err%0d_pulse got %b want 0", with_set, fault_o); else passed++;
    @(negedge clk_i);
    total++; if (pc_o !== (with_set ? 32'h100 : 32'h8)) $display("FAIL err%0d_pc got %h want %h", with_set, pc_o, with_set ? 32'h100 : 32'h8); else passed++;
    total++; if (ir_o !== (with_set ? 64'h100 : 64'h8)) $display("FAIL err%0d_ir got %h want %h", with_set, ir_o, with_set ? 64'h100 : 64'h8); else passed++;
    err_en = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset;
    do_reset();
    mem[127] = 32'h0000_0ABC; mem[0] = 32'h1234_0000;
    pc_set_i = 1'b1; pc_target_i = 32'hFFFF_FFFC;
    rst_i = 1'b1;
    @(negedge clk_i);
    pc_set_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    total++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", pc_o); else passed++;
    total++; if (ir_o !== 64'hABC) $display("FAIL wrap_ir got %h want abc", ir_o); else passed++;
    total++; if (bus_adr_o !== 32'h0) $display("FAIL wrap_adr got %h want 0", bus_adr_o); else passed++;
    total++; if (bus_cyc_o !== 1'b1) $display("FAIL wrap_cyc got %b want 1", bus_cyc_o); else passed++;
    #2 rst_i = 1'b0;
    #1;
    total++; if (bus_cyc_o !== 1'b0) $display("FAIL async_cyc got %b want 0", bus_cyc_o); else passed++;
    total++; if (bus_stb_o !== 1'b0) $display("FAIL async_stb got %b want 0", bus_stb_o); else passed++;
    total++; if (ir_o !== 64'h0) $display("FAIL async_ir got %h want 0", ir_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL async_pc got %h want 0", pc_o); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset();
    test_short();
    test_long_wait();
    test_stall();
    test_redirect();
    test_bus_err(1'b0);
    test_bus_err(1'b1);
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
